// File: rtl/calc_sequencer.sv
// Command-driven initiator for the 16-bit combinational calculator: issues one op at a time,
// chains results through an accumulator, and returns each result over a valid/ready port.
module calc_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_operand,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_overflow,
    output logic             resp_error,
    output logic             ovf_sticky,
    output logic [15:0]      op_count,
    output logic [WIDTH-1:0] calc_in1,
    output logic [WIDTH-1:0] calc_in2,
    output logic [3:0]       calc_opcode,
    input  logic [WIDTH-1:0] calc_result,
    input  logic             calc_overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] OP_LAST_CALC = 4'b1001;
    localparam logic [3:0] OP_CLEAR     = 4'b1110;
    localparam logic [3:0] OP_LOAD      = 4'b1111;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] calc_in1_q, calc_in1_d;
    logic [WIDTH-1:0] calc_in2_q, calc_in2_d;
    logic [3:0]       calc_opcode_q, calc_opcode_d;
    logic [WIDTH-1:0] resp_result_q, resp_result_d;
    logic             resp_overflow_q, resp_overflow_d;
    logic             resp_error_q, resp_error_d;
    logic             ovf_sticky_q, ovf_sticky_d;
    logic [15:0]      op_count_q, op_count_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            acc_q           <= '0;
            calc_in1_q      <= '0;
            calc_in2_q      <= '0;
            calc_opcode_q   <= '0;
            resp_result_q   <= '0;
            resp_overflow_q <= 1'b0;
            resp_error_q    <= 1'b0;
            ovf_sticky_q    <= 1'b0;
            op_count_q      <= '0;
        end else begin
            state_q         <= state_d;
            acc_q           <= acc_d;
            calc_in1_q      <= calc_in1_d;
            calc_in2_q      <= calc_in2_d;
            calc_opcode_q   <= calc_opcode_d;
            resp_result_q   <= resp_result_d;
            resp_overflow_q <= resp_overflow_d;
            resp_error_q    <= resp_error_d;
            ovf_sticky_q    <= ovf_sticky_d;
            op_count_q      <= op_count_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        acc_d           = acc_q;
        calc_in1_d      = calc_in1_q;
        calc_in2_d      = calc_in2_q;
        calc_opcode_d   = calc_opcode_q;
        resp_result_d   = resp_result_q;
        resp_overflow_d = resp_overflow_q;
        resp_error_d    = resp_error_q;
        ovf_sticky_d    = ovf_sticky_q;
        op_count_d      = op_count_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    resp_overflow_d = 1'b0;
                    resp_error_d    = 1'b0;
                    state_d         = RESP;
                    if (cmd_op <= OP_LAST_CALC) begin
                        calc_in1_d    = acc_q;
                        calc_in2_d    = cmd_operand;
                        calc_opcode_d = cmd_op;
                        state_d       = WAIT;
                    end else if (cmd_op == OP_LOAD) begin
                        acc_d         = cmd_operand;
                        resp_result_d = cmd_operand;
                    end else if (cmd_op == OP_CLEAR) begin
                        acc_d         = '0;
                        ovf_sticky_d  = 1'b0;
                        resp_result_d = '0;
                    end else begin
                        // Undefined calculator codes never reach the calculator.
                        resp_result_d = acc_q;
                        resp_error_d  = 1'b1;
                    end
                end
            end
            WAIT: begin
                acc_d           = calc_result;
                resp_result_d   = calc_result;
                resp_overflow_d = calc_overflow;
                resp_error_d    = 1'b0;
                ovf_sticky_d    = ovf_sticky_q | calc_overflow;
                op_count_d      = op_count_q + 16'd1;
                state_d         = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_ready     = (state_q == IDLE);
    assign resp_valid    = (state_q == RESP);
    assign resp_result   = resp_result_q;
    assign resp_overflow = resp_overflow_q;
    assign resp_error    = resp_error_q;
    assign ovf_sticky    = ovf_sticky_q;
    assign op_count      = op_count_q;
    assign calc_in1      = calc_in1_q;
    assign calc_in2      = calc_in2_q;
    assign calc_opcode   = calc_opcode_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer; the bench plays the calculator, returning a
// hand-picked result per vector, and checks what the sequencer issues and returns.
module tb_calc_sequencer;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [15:0] cmd_operand;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_result;
    logic        resp_overflow;
    logic        resp_error;
    logic        ovf_sticky;
    logic [15:0] op_count;
    logic [15:0] calc_in1;
    logic [15:0] calc_in2;
    logic [3:0]  calc_opcode;
    logic [15:0] calc_result;
    logic        calc_overflow;

    int vectorCount = 0;
    int miscompareCount = 0;

    logic [15:0] accM;
    logic        stickyM;
    logic [15:0] countM;
    logic [15:0] calcIn1M;
    logic [15:0] calcIn2M;
    logic [3:0]  calcOpM;

    calc_sequencer #(.WIDTH(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_operand   (cmd_operand),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_result   (resp_result),
        .resp_overflow (resp_overflow),
        .resp_error    (resp_error),
        .ovf_sticky    (ovf_sticky),
        .op_count      (op_count),
        .calc_in1      (calc_in1),
        .calc_in2      (calc_in2),
        .calc_opcode   (calc_opcode),
        .calc_result   (calc_result),
        .calc_overflow (calc_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectorCount++;
        if (got !== exp) begin
            miscompareCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic resetModel();
        accM     = '0;
        stickyM  = 1'b0;
        countM   = '0;
        calcIn1M = '0;
        calcIn2M = '0;
        calcOpM  = '0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".resp_valid"},    resp_valid, 0);
        checkOutput({tag, ".resp_result"},   resp_result, 0);
        checkOutput({tag, ".resp_overflow"}, resp_overflow, 0);
        checkOutput({tag, ".resp_error"},    resp_error, 0);
        checkOutput({tag, ".ovf_sticky"},    ovf_sticky, 0);
        checkOutput({tag, ".op_count"},      op_count, 0);
        checkOutput({tag, ".calc_in1"},      calc_in1, 0);
        checkOutput({tag, ".calc_in2"},      calc_in2, 0);
        checkOutput({tag, ".calc_opcode"},   calc_opcode, 0);
    endtask

    // Issues one command, plays the calculator with stubRes/stubOvf, checks latency and
    // response, optionally withholds resp_ready for holdCycles edges.
    task automatic applyStimulus(input string tag, input logic [3:0] op, input logic [15:0] operand,
                                 input logic [15:0] stubRes, input logic stubOvf,
                                 input logic [15:0] expRes, input logic expOvf, input logic expErr,
                                 input int holdCycles);
        int expLat;
        int lat;
        int waitCount;
        bit isCalc;
        isCalc = (op <= 4'd9);
        expLat = isCalc ? 2 : 1;
        if (isCalc) begin
            calcIn1M = accM;
            calcIn2M = operand;
            calcOpM  = op;
            accM     = stubRes;
            stickyM  = stickyM | stubOvf;
            countM   = countM + 16'd1;
        end else if (op == 4'b1111) begin
            accM = operand;
        end else if (op == 4'b1110) begin
            accM    = '0;
            stickyM = 1'b0;
        end

        calc_result   = stubRes;
        calc_overflow = stubOvf;
        resp_ready    = (holdCycles == 0);
        cmd_op        = op;
        cmd_operand   = operand;
        cmd_valid     = 1'b1;
        waitCount = 0;
        while (!cmd_ready && waitCount < 10) begin
            @(posedge clk); #1;
            waitCount++;
        end
        checkOutput({tag, ".cmd_ready"}, cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checkOutput({tag, ".cmd_ready_after_accept"}, cmd_ready, 0);

        lat = 1;
        while (!resp_valid && lat < 6) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({tag, ".latency"},       lat, expLat);
        checkOutput({tag, ".resp_result"},   resp_result, expRes);
        checkOutput({tag, ".resp_overflow"}, resp_overflow, expOvf);
        checkOutput({tag, ".resp_error"},    resp_error, expErr);
        checkOutput({tag, ".ovf_sticky"},    ovf_sticky, stickyM);
        checkOutput({tag, ".op_count"},      op_count, countM);
        checkOutput({tag, ".calc_in1"},      calc_in1, calcIn1M);
        checkOutput({tag, ".calc_in2"},      calc_in2, calcIn2M);
        checkOutput({tag, ".calc_opcode"},   calc_opcode, calcOpM);

        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk); #1;
            checkOutput({tag, ".hold_valid"},     resp_valid, 1);
            checkOutput({tag, ".hold_result"},    resp_result, expRes);
            checkOutput({tag, ".hold_cmd_ready"}, cmd_ready, 0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        checkOutput({tag, ".idle_cmd_ready"},  cmd_ready, 1);
        checkOutput({tag, ".idle_resp_valid"}, resp_valid, 0);
    endtask

    initial begin
        reset         = 1'b1;
        cmd_valid     = 1'b0;
        cmd_op        = '0;
        cmd_operand   = '0;
        resp_ready    = 1'b0;
        calc_result   = '0;
        calc_overflow = 1'b0;
        resetModel();
        #1;
        checkResetValues("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("reset.cmd_ready", cmd_ready, 1);

        applyStimulus("load100",   4'b1111, 16'd100,   16'h0000, 1'b0, 16'd100,  1'b0, 1'b0, 0);
        applyStimulus("add23",     4'b0000, 16'd23,    16'd123,  1'b0, 16'd123,  1'b0, 1'b0, 0);
        applyStimulus("load32767", 4'b1111, 16'h7FFF,  16'h0000, 1'b0, 16'h7FFF, 1'b0, 1'b0, 0);
        applyStimulus("op1000",    4'b1000, 16'd1,     16'h8000, 1'b1, 16'h8000, 1'b1, 1'b0, 0);
        applyStimulus("clear",     4'b1110, 16'h1234,  16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 0);
        applyStimulus("load25",    4'b1111, 16'd25,    16'h0000, 1'b0, 16'd25,   1'b0, 1'b0, 0);
        applyStimulus("op0011",    4'b0011, 16'd10,    16'd2,    1'b1, 16'd2,    1'b1, 1'b0, 0);
        applyStimulus("op0010",    4'b0010, 16'd5,     16'd10,   1'b0, 16'd10,   1'b0, 1'b0, 0);
        applyStimulus("loadm5",    4'b1111, 16'hFFFB,  16'h0000, 1'b0, 16'hFFFB, 1'b0, 1'b0, 0);
        applyStimulus("illegal",   4'b1011, 16'h0042,  16'h5555, 1'b1, 16'hFFFB, 1'b0, 1'b1, 0);
        applyStimulus("illegal2",  4'b1101, 16'h0001,  16'h5555, 1'b1, 16'hFFFB, 1'b0, 1'b1, 0);
        applyStimulus("addhold",   4'b0000, 16'd3,     16'hFFFE, 1'b0, 16'hFFFE, 1'b0, 1'b0, 5);

        // Reset in the WAIT cycle of an add must discard it entirely.
        calc_result   = 16'h0BAD;
        calc_overflow = 1'b1;
        cmd_op        = 4'b0000;
        cmd_operand   = 16'd9;
        cmd_valid     = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checkOutput("midreset.in_wait", resp_valid, 0);
        reset = 1'b1;
        #1;
        resetModel();
        checkResetValues("midreset");
        checkOutput("midreset.cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checkResetValues("midreset.after");

        applyStimulus("postreset", 4'b0000, 16'd7, 16'd7, 1'b0, 16'd7, 1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Command-driven initiator for the 16-bit combinational calculator. It accepts one operation at a time over a valid/ready command port and drives the calculator's `in1`/`in2`/`opCode` inputs from registers. It captures `result`/`overflow` one cycle later and returns them over a valid/ready response port. An internal accumulator is always fed to `in1`, so operations chain; a sticky overflow flag and a completed-operation counter are kept alongside.

## Interface
- `WIDTH`, 16: datapath width. Must match the calculator; only 16 is supported.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  sequencer can accept a command
- `cmd_op`  in  4  opcode: 0000–1001 calculator ops, 1110 clear, 1111 load
- `cmd_operand`  in  16  signed; drives `in2`, or the load value for 1111
- `resp_valid`  out  1  response present
- `resp_ready`  in  1  consumer accepts the response
- `resp_result`  out  16  signed result (new accumulator value)
- `resp_overflow`  out  1  calculator overflow bit for this op
- `resp_error`  out  1  illegal opcode (1010–1101)
- `ovf_sticky`  out  1  OR of all `resp_overflow` since the last clear/reset
- `op_count`  out  16  completed calculator ops, wraps modulo 2^16
- `calc_in1`, `calc_in2`  out  16  to calculator `in1`, `in2`
- `calc_opcode`  out  4  to calculator `opCode`
- `calc_result`  in  16  from calculator `result`
- `calc_overflow`  in  1  from calculator `overflow`

## Operation
- States: IDLE, WAIT, RESP.
- `cmd_ready` = (state == IDLE). A command is accepted on a rising edge with `cmd_valid & cmd_ready`.
- **Accept with a calculator op (0000–1001):**
  - Register `calc_in1 <= acc`, `calc_in2 <= cmd_operand`, `calc_opcode <= cmd_op`.
  - State goes to WAIT.
- **WAIT (exactly one cycle):** on the next edge:
  - `acc <= calc_result`; `resp_result <= calc_result`; `resp_overflow <= calc_overflow`; `resp_error <= 0`.
  - `ovf_sticky <= ovf_sticky | calc_overflow`; `op_count <= op_count + 1`.
  - State goes to RESP.
- **Accept with 1111 (load):** `acc <= cmd_operand`, `resp_result <= cmd_operand`, overflow 0, error 0, straight to RESP. Calculator ports unchanged. `op_count` unchanged.
- **Accept with 1110 (clear):** `acc <= 0`, `ovf_sticky <= 0`, `resp_result <= 0`, overflow 0, error 0, straight to RESP. `op_count` unchanged.
- **Accept with 1010–1101 (illegal):**
  - The calculator has no defined output for these codes, so they are never issued to it.
  - Response: `resp_result <= acc` (acc unchanged), `resp_error <= 1`, overflow 0, straight to RESP.
- **RESP:** `resp_valid` = 1. All `resp_*` are held stable until `resp_valid & resp_ready`; on that edge state goes to IDLE.
- `calc_*` outputs hold their last issued values at all times outside accept edges.
- Arithmetic is done entirely by the calculator. The sequencer performs no width extension; wrap-around results (for example 0x7FFF + 1 = 0x8000) are stored as returned.

## Timing
- Reset values, applied immediately on `reset` assertion regardless of state:
  - State IDLE, so `cmd_ready` = 1 while reset is deasserted and in IDLE.
  - `resp_valid` 0; `resp_result`, `resp_overflow`, `resp_error` all 0.
  - `acc` 0, `ovf_sticky` 0, `op_count` 0.
  - `calc_in1`, `calc_in2`, `calc_opcode` all 0.
- Reset mid-operation (WAIT or RESP) discards the in-flight op. No response is produced and no counter or flag update occurs.
- Latency, counted from the accept edge to `resp_valid` high:
  - Calculator op: 2 edges (accept→WAIT, WAIT→RESP).
  - Load, clear, illegal: 1 edge.
- Throughput: at most one command per 3 cycles for calculator ops and per 2 cycles for the others. `cmd_ready` is low throughout WAIT and RESP; no overlap or buffering.
- `resp_ready` may be held high in advance; the response then completes on the first RESP edge. Backpressure of any length holds RESP.
- `cmd_valid` asserted during WAIT/RESP is ignored until IDLE; the command is not dropped by the sequencer, because the source must hold it until ready.
- `op_count` at 0xFFFF increments to 0x0000.

## Test plan
- Load 100, then op 0000 with operand 23 → load response 100 after 1 cycle; add response `resp_result` = 123, overflow 0, 2 cycles after accept; `op_count` = 1.
- Load 32767, then op 1000 → result 0x8000 (−32768), `resp_overflow` = 1, `ovf_sticky` = 1. Then clear → result 0, `ovf_sticky` = 0.
- Load 25, op 0011 → result 2, overflow 1. Then op 0010 → result 10, overflow 0, `ovf_sticky` stays 1.
- Load −5, op 1011 → `resp_error` = 1, `resp_result` = −5, `calc_opcode` unchanged, `op_count` unchanged.
- Add issued with `resp_ready` held low 5 cycles → `resp_valid` and result stable all 5 cycles, `cmd_ready` = 0; handshake on the 6th edge returns to IDLE.
- Assert `reset` during WAIT of an add → all outputs at reset values immediately, no response, `acc` = 0, `op_count` = 0.
